// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
//
// Iterative AES-128 key schedule that produces one round key per clock and
// presents the final (round-10) key to the downstream decryption core. A
// single SubWord path (four S-box byte lookups) is reused by every round.
//
// Ports:
//   clk           rising-edge system clock
//   reset_n       synchronous reset, active-HIGH despite the name
//   cipher_key    AES-128 key, w0 = [127:96] ... w3 = [31:0]
//   key_start     start request, honoured only while not busy
//   key_busy      expansion in progress
//   key_ready     round_key_10 valid, held until next accepted start/reset
//   round_key_10  final round key
//   rk_idx        stored round-key read index 0..10
//   rk_data       stored round key at rk_idx, one-cycle read latency
//
// Optional feature macro: AES_KEY_STORE_EN
//   defined   : an 11-entry register file keeps round keys 0..10 and
//               rk_data is a registered read of entry rk_idx (0 beyond 10)
//   undefined : no storage, rk_idx ignored, rk_data tied to 0
// ---------------------------------------------------------------------------
module aes_key_expander #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [KW-1:0] cipher_key,
  input  logic          key_start,
  output logic          key_busy,
  output logic          key_ready,
  output logic [KW-1:0] round_key_10,
  input  logic [3:0]    rk_idx,
  output logic [KW-1:0] rk_data
);

  if (NR != 10 || KW != 128) begin : gen_param_check
    $error("aes_key_expander supports only NR = 10 and KW = 128");
  end

  // Forward S-box, row 0 in the top bits, so entry b lives at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, next_state;
  logic          load_key;
  logic          last_round;
  logic [3:0]    round_cnt;
  logic [7:0]    rcon;
  logic [KW-1:0] work_key;
  logic [KW-1:0] next_key;
  logic [31:0]   temp;
  logic [31:0]   w0n, w1n, w2n, w3n;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One key-schedule round: RotWord + SubWord + rcon on w3, then the
  // chained XORs across the four words.
  always_comb begin
    temp     = sub_word({work_key[23:0], work_key[31:24]}) ^ {rcon, 24'h0};
    w0n      = work_key[127:96] ^ temp;
    w1n      = work_key[95:64] ^ w0n;
    w2n      = work_key[63:32] ^ w1n;
    w3n      = work_key[31:0] ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE accepts a start exactly like IDLE; EXPAND ignores it.
  always_comb begin
    next_state = state;
    load_key   = 1'b0;
    last_round = 1'b0;
    key_busy   = 1'b0;
    key_ready  = 1'b0;
    case (state)
      IDLE, DONE: begin
        key_ready = (state == DONE);
        if (key_start) begin
          next_state = EXPAND;
          load_key   = 1'b1;
        end
      end
      EXPAND: begin
        key_busy = 1'b1;
        if (round_cnt == 4'(NR)) begin
          next_state = DONE;
          last_round = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Working key, round counter and rcon (advanced by xtime each round).
  always_ff @(posedge clk) begin
    if (reset_n) begin
      work_key     <= '0;
      round_cnt    <= 4'd0;
      rcon         <= 8'h01;
      round_key_10 <= '0;
    end else if (load_key) begin
      work_key  <= cipher_key;
      round_cnt <= 4'd1;
      rcon      <= 8'h01;
    end else if (state == EXPAND) begin
      work_key <= next_key;
      rcon     <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      if (last_round) begin
        round_key_10 <= next_key;
        round_cnt    <= 4'd0;
      end else begin
        round_cnt <= round_cnt + 4'd1;
      end
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [KW-1:0] rk_store [0:NR];

  // Round 0 is captured on the start edge, round N on the edge computing it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i <= NR; i++) begin
        rk_store[i] <= '0;
      end
      rk_data <= '0;
    end else begin
      if (load_key) begin
        rk_store[0] <= cipher_key;
      end else if (state == EXPAND) begin
        rk_store[round_cnt] <= next_key;
      end
      rk_data <= (rk_idx <= 4'(NR)) ? rk_store[rk_idx] : '0;
    end
  end
`else
  logic unused_rk_idx;
  assign unused_rk_idx = ^rk_idx;
  assign rk_data       = '0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
//
// Directed plus randomized bench for aes_key_expander. Expected keys come
// from a reference key schedule in the FIPS-197 word form, whose S-box is
// built from the GF(2^8) inverse and affine transform.
// Honours AES_KEY_STORE_EN to exercise the round-key store.
// ---------------------------------------------------------------------------
module tb_aes_key_expander;

  logic         clk;
  logic         reset_n;
  logic [127:0] cipher_key;
  logic         key_start;
  logic         key_busy;
  logic         key_ready;
  logic [127:0] round_key_10;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_ref [256];

  aes_key_expander dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cipher_key   (cipher_key),
    .key_start    (key_start),
    .key_busy     (key_busy),
    .key_ready    (key_ready),
    .round_key_10 (round_key_10),
    .rk_idx       (rk_idx),
    .rk_data      (rk_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  // S-box entry: multiplicative inverse (a^254, 0 maps to 0) then affine map.
  function automatic logic [7:0] sbox_entry(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    logic [7:0] r;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = rotl1(r);
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  // Full 44-word expansion; returns round key r (0..10).
  function automatic logic [127:0] model_round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present a key and pulse key_start across exactly one rising edge.
  task automatic applyStimulus(input logic [127:0] key);
    cipher_key = key;
    key_start  = 1'b1;
    tick();
    key_start  = 1'b0;
  endtask

  // Bounded wait for key_ready; cycles counts edges after the call.
  task automatic waitReady(output int cycles);
    cycles = 0;
    while (!key_ready && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    logic [127:0] k1, k2, k_fixed, prev_rk;
    int           lat;
    int           pulses;

    for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_entry(8'(i));

    reset_n    = 1'b1;
    key_start  = 1'b0;
    cipher_key = '0;
    rk_idx     = 4'd0;
    repeat (2) tick();
    reset_n = 1'b0;

    checkOutput("reset_busy", 128'(key_busy), 128'(0));
    checkOutput("reset_ready", 128'(key_ready), 128'(0));
    checkOutput("reset_rk10", round_key_10, '0);
    checkOutput("reset_rkdata", rk_data, '0);

    // FIPS-197 key, exact 10-clock latency.
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("fips_busy_after_start", 128'(key_busy), 128'(1));
    checkOutput("fips_ready_after_start", 128'(key_ready), 128'(0));
    waitReady(lat);
    checkOutput("fips_latency", 128'(lat), 128'(10));
    checkOutput("fips_busy_done", 128'(key_busy), 128'(0));
    checkOutput("fips_rk10", round_key_10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_STORE_EN
    rk_idx = 4'd1;
    tick();
    checkOutput("store_rk1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_idx = 4'd0;
    tick();
    checkOutput("store_rk0", rk_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk_idx = 4'd12;
    tick();
    checkOutput("store_idx12", rk_data, '0);
`else
    rk_idx = 4'd1;
    tick();
    checkOutput("nostore_rkdata", rk_data, '0);
`endif

    repeat (3) tick();
    checkOutput("done_hold_ready", 128'(key_ready), 128'(1));
    checkOutput("done_hold_rk10", round_key_10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // FIPS-197 C.1 key started from DONE, then back to the first key.
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("c1_ready_drop", 128'(key_ready), 128'(0));
    checkOutput("c1_busy", 128'(key_busy), 128'(1));
    waitReady(lat);
    checkOutput("c1_latency", 128'(lat), 128'(10));
    checkOutput("c1_rk10", round_key_10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c);
    checkOutput("restart_ready_drop", 128'(key_ready), 128'(0));
    waitReady(lat);
    checkOutput("restart_rk10", round_key_10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Randomized keys against the reference schedule.
    for (int n = 0; n < 4; n++) begin
      k1 = rand_key();
      applyStimulus(k1);
      waitReady(lat);
      checkOutput($sformatf("rand%0d_latency", n), 128'(lat), 128'(10));
      checkOutput($sformatf("rand%0d_rk10", n), round_key_10, model_round_key(k1, 10));
    end

    // Start pulse at cycle 4 of an expansion is ignored; key change too.
    k1 = rand_key();
    k2 = rand_key();
    applyStimulus(k1);
    repeat (3) tick();
    cipher_key = k2;
    key_start  = 1'b1;
    tick();
    key_start  = 1'b0;
    waitReady(lat);
    checkOutput("ignore_latency", 128'(lat + 4), 128'(10));
    checkOutput("ignore_rk10", round_key_10, model_round_key(k1, 10));
    repeat (12) tick();
    checkOutput("ignore_no_second_ready", 128'(key_ready), 128'(1));
    checkOutput("ignore_no_second_busy", 128'(key_busy), 128'(0));
    checkOutput("ignore_rk10_stable", round_key_10, model_round_key(k1, 10));

    // Reset at cycle 6 of EXPAND aborts cleanly.
    applyStimulus(rand_key());
    repeat (5) tick();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    checkOutput("midreset_busy", 128'(key_busy), 128'(0));
    checkOutput("midreset_ready", 128'(key_ready), 128'(0));
    checkOutput("midreset_rk10", round_key_10, '0);
    checkOutput("midreset_rkdata", rk_data, '0);
    k1 = rand_key();
    applyStimulus(k1);
    waitReady(lat);
    checkOutput("postreset_latency", 128'(lat), 128'(10));
    checkOutput("postreset_rk10", round_key_10, model_round_key(k1, 10));

`ifdef AES_KEY_STORE_EN
    for (int r = 0; r <= 10; r++) begin
      rk_idx = 4'(r);
      tick();
      checkOutput($sformatf("store_rand_rk%0d", r), rk_data, model_round_key(k1, r));
    end
    rk_idx = 4'd15;
    tick();
    checkOutput("store_idx15", rk_data, '0);
`endif

    // key_start held high: one-cycle ready pulse every 11 clocks.
    k_fixed    = rand_key();
    prev_rk    = model_round_key(k_fixed, 10);
    cipher_key = k_fixed;
    key_start  = 1'b1;
    pulses     = 0;
    for (int t = 1; t <= 44; t++) begin
      tick();
      if (key_ready) begin
        pulses++;
        checkOutput($sformatf("cont_pulse_pos_t%0d", t), 128'(t % 11), 128'(0));
        checkOutput($sformatf("cont_rk10_t%0d", t), round_key_10, prev_rk);
      end
    end
    key_start = 1'b0;
    checkOutput("cont_pulse_count", 128'(pulses), 128'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES-128 key schedule, one round key per clock.
- Sits directly upstream of the AES decryption core. It takes the 128-bit cipher key and produces the round-10 key, which the decrypt core uses as its starting key. It also flags when that key is valid.
- Shares one S-box instance (SubWord, 4 byte lookups) across all iterations.

Parameters:
- NR, 10, number of expansion rounds; only 10 (AES-128) is supported, and other values are a synthesis error.
- KW, 128, key width in bits; fixed at 128.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  synchronous reset, active-high (asserted = 1, sampled on rising clk).
- cipher_key  input  128  AES-128 key; word w0 = [127:96], w3 = [31:0].
- key_start  input  1  request to begin expansion; sampled only when key_busy = 0.
- key_busy  output  1  expansion in progress.
- key_ready  output  1  round_key_10 valid; held until the next accepted start or reset.
- round_key_10  output  128  final (round-10) round key.
- rk_idx  input  4  round-key read index 0..10 (only with AES_KEY_STORE_EN).
- rk_data  output  128  stored round key at rk_idx (only with AES_KEY_STORE_EN).

Behaviour:
- Reset (reset_n = 1 at a rising edge), evaluated before any other event:
  - state = IDLE, round counter = 0, rcon = 8'h01.
  - key_busy = 0, key_ready = 0, round_key_10 = 0, rk_data = 0.
  - A reset during EXPAND aborts the expansion; no partial key is ever flagged ready.
- State IDLE:
  - key_start = 1 at edge T0 loads cipher_key into the working register (round 0), sets counter = 1 and rcon = 01, and clears key_ready.
  - State becomes EXPAND and key_busy = 1 from T0 onward.
- State EXPAND (one round per edge):
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
  - rcon sequence: 01,02,04,08,10,20,40,80,1B,36, computed by xtime (shift left 1; if the MSB was set, XOR 1B).
  - The counter increments each edge.
  - At the edge that computes round 10 (T0 + 10):
    - round_key_10 <= result, key_ready <= 1, key_busy <= 0.
    - State becomes DONE.
  - Start-to-ready latency is exactly 10 clocks.
- State DONE:
  - Outputs are held stable.
  - key_start = 1 behaves exactly as in IDLE: new key loaded, key_ready drops to 0 on the same edge, key_busy = 1.
- key_start while key_busy = 1 is ignored and not queued. cipher_key changes during EXPAND have no effect.
- key_start held high continuously: a new expansion is accepted on the edge after each completion (DONE → EXPAND). In that case key_ready is high for exactly 1 cycle.
- Counter wrap: the counter never exceeds 10; it returns to 0 on entry to DONE.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- With the macro defined:
  - An 11 × 128 register file stores round keys 0..10 as they are produced (round 0 on the start edge).
  - rk_data is a registered read of entry rk_idx, giving 1-cycle read latency.
  - rk_idx > 10 returns 0.
  - Contents are valid only while key_ready = 1. Reset clears all entries.
- Without the macro:
  - No storage array.
  - rk_idx is unused and rk_data is tied to 0.

Test Plan:
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, key_start for 1 cycle → key_ready rises exactly 10 clocks later; round_key_10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f → round_key_10 = 13111d7fe3944a17f307a78b4d2b30c5. Then start again with the previous key → key_ready drops on the start edge and the new result matches the first vector.
- Start ignored when busy: pulse key_start at cycle 4 of an expansion with a different key → result unchanged, still ready at +10, and no second expansion follows.
- Reset mid-run: assert reset_n = 1 at cycle 6 of EXPAND → next cycle key_busy = 0, key_ready = 0, round_key_10 = 0. A fresh start then completes normally in 10 clocks.
- Continuous key_start = 1 with a fixed key → key_ready pulses for 1 cycle every 11 clocks; round_key_10 is constant.
- AES_KEY_STORE_EN: after the 2b7e... expansion, rk_idx = 1 → rk_data = a0fafe1788542cb123a339392a6c7605 on the next cycle. rk_idx = 0 returns the cipher key. rk_idx = 12 returns 0.
